onehot_req_arbiter: RTL and testbench

ONEHOT_REQ_ARBITER -- requirements
Module: onehot_req_arbiter

---
 rtl/onehot_req_arbiter.sv | 98 +++++++++
 tb/tb_onehot_req_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter turning request-line rising edges into a registered one-hot grant.
// Optional saturating overflow counter on port ovf_cnt, enabled by defining ARB_OVF_CNT_EN.
module onehot_req_arbiter #(
  parameter int N = 8  // fixed at 8: grant drives an 8-to-3 encoder
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         clr,
  output logic [N-1:0] grant,
  output logic         grant_vld,
  input  logic         grant_rdy,
  output logic [N-1:0] pending
`ifdef ARB_OVF_CNT_EN
  ,
  output logic [7:0]   ovf_cnt
`endif
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  req_prev;
  logic [N-1:0]  req_edge;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          accept;
  logic          load;
  logic [N-1:0]  acc_mask;
  logic [N-1:0]  cand;
  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;

  assign req_edge = req_in & ~req_prev;
  assign accept   = grant_vld & grant_rdy;
  assign acc_mask = accept ? grant : '0;
  assign load     = ~grant_vld | accept;
  // The line being accepted this cycle may not win again until its re-pulse lands in pending.
  assign cand     = pending & ~acc_mask;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev  <= '0;
      pending   <= '0;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      req_prev <= req_in;
      if (clr) begin
        pending   <= '0;
        grant     <= '0;
        grant_vld <= 1'b0;
      end else begin
        pending <= cand | req_edge;
        if (accept) ptr <= grant_idx + 1'b1;
        if (load) begin
          if (found) begin
            grant     <= {{(N-1){1'b0}}, 1'b1} << win;
            grant_vld <= 1'b1;
            grant_idx <= win;
          end else begin
            grant     <= '0;
            grant_vld <= 1'b0;
          end
        end
      end
    end
  end

`ifdef ARB_OVF_CNT_EN
  logic ovf_hit;
  assign ovf_hit = |(req_edge & cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_hit && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed bench for onehot_req_arbiter; overflow counter steps run when ARB_OVF_CNT_EN is defined.
module tb_onehot_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       clr;
  logic [7:0] grant;
  logic       grant_vld;
  logic       grant_rdy;
  logic [7:0] pending;
`ifdef ARB_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  onehot_req_arbiter #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .clr       (clr),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_rdy (grant_rdy),
    .pending   (pending)
`ifdef ARB_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; grant must never be multi-hot.
  task automatic step();
    @(posedge clk);
    #1;
    check("onehot0", {7'd0, $onehot0(grant)}, 8'h01);
  endtask

  task automatic expect_state(input string tag, input logic [7:0] g, input logic v, input logic [7:0] p);
    check({tag, "_grant"}, grant, g);
    check({tag, "_vld"}, {7'd0, grant_vld}, {7'd0, v});
    check({tag, "_pending"}, pending, p);
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'h00; clr = 1'b0; grant_rdy = 1'b1;
    #12;
    expect_state("reset", 8'h00, 1'b0, 8'h00);
`ifdef ARB_OVF_CNT_EN
    check("reset_ovf", ovf_cnt, 8'h00);
`endif
    rst_n = 1'b1;
    step(); step();

    // Single request on line 2: pending after one edge, grant after two, cleared on accept.
    req_in = 8'h04;
    step(); expect_state("r26_t1", 8'h00, 1'b0, 8'h04);
    step(); expect_state("r26_t2", 8'h04, 1'b1, 8'h04);
    step(); expect_state("r26_t3", 8'h00, 1'b0, 8'h00);
    req_in = 8'h00;

    // Reset again so ptr restarts at 0.
    step();
    rst_n = 1'b0; #2; rst_n = 1'b1;

    // Lines 0 and 7 together: 0x01 then 0x80 back-to-back, ptr wraps to 0.
    req_in = 8'h81;
    step(); expect_state("r27_t1", 8'h00, 1'b0, 8'h81);
    step(); expect_state("r27_t2", 8'h01, 1'b1, 8'h81);
    step(); expect_state("r27_t3", 8'h80, 1'b1, 8'h80);
    step(); expect_state("r27_t4", 8'h00, 1'b0, 8'h00);
    req_in = 8'h00;
    step();
    // ptr==0 shows up as line 0 winning over line 1.
    req_in = 8'h03;
    step(); expect_state("ptr0_t1", 8'h00, 1'b0, 8'h03);
    step(); expect_state("ptr0_t2", 8'h01, 1'b1, 8'h03);
    step(); expect_state("ptr0_t3", 8'h02, 1'b1, 8'h02);
    step(); expect_state("ptr0_t4", 8'h00, 1'b0, 8'h00);
    req_in = 8'h00;
    step();

    // Grant 0x10 held under backpressure while line 1 pulses (ptr=2 here).
    grant_rdy = 1'b0;
    req_in = 8'h10;
    step(); expect_state("r28_t1", 8'h00, 1'b0, 8'h10);
    step(); expect_state("r28_t2", 8'h10, 1'b1, 8'h10);
    req_in = 8'h12; step(); expect_state("r28_h1", 8'h10, 1'b1, 8'h12);
    req_in = 8'h10; step(); expect_state("r28_h2", 8'h10, 1'b1, 8'h12);
    req_in = 8'h12; step(); expect_state("r28_h3", 8'h10, 1'b1, 8'h12);
    req_in = 8'h10; step(); expect_state("r28_h4", 8'h10, 1'b1, 8'h12);
    step();                 expect_state("r28_h5", 8'h10, 1'b1, 8'h12);
    grant_rdy = 1'b1;
    step(); expect_state("r28_acc", 8'h02, 1'b1, 8'h02);
    req_in = 8'h00;
    step(); expect_state("r28_done", 8'h00, 1'b0, 8'h00);

    // Line 3 re-pulses exactly when its grant is accepted (ptr=2 here).
    req_in = 8'h08;
    step(); expect_state("r29_t1", 8'h00, 1'b0, 8'h08);
    req_in = 8'h00;
    step(); expect_state("r29_t2", 8'h08, 1'b1, 8'h08);
    req_in = 8'h08;
    step(); expect_state("r29_t3", 8'h00, 1'b0, 8'h08);
    step(); expect_state("r29_t4", 8'h08, 1'b1, 8'h08);
    req_in = 8'h00;
    step(); expect_state("r29_t5", 8'h00, 1'b0, 8'h00);

    // clr with everything pending and a grant outstanding (ptr=4 here).
    grant_rdy = 1'b0;
    req_in = 8'hFF;
    step(); expect_state("r30_t1", 8'h00, 1'b0, 8'hFF);
    step(); expect_state("r30_t2", 8'h10, 1'b1, 8'hFF);
    clr = 1'b1;
    step(); expect_state("r30_clr", 8'h00, 1'b0, 8'h00);
    clr = 1'b0;
    step(); expect_state("r30_after", 8'h00, 1'b0, 8'h00);
    req_in = 8'h00;
    step();

    // Asynchronous reset mid-handshake, then a line already high counts as an edge.
    req_in = 8'h20;
    step(); expect_state("r22_t1", 8'h00, 1'b0, 8'h20);
    step(); expect_state("r22_t2", 8'h20, 1'b1, 8'h20);
    #2; rst_n = 1'b0; #1;
    expect_state("r22_async", 8'h00, 1'b0, 8'h00);
    #1; rst_n = 1'b1;
    step(); expect_state("r23_t1", 8'h00, 1'b0, 8'h20);
    step(); expect_state("r23_t2", 8'h20, 1'b1, 8'h20);
    grant_rdy = 1'b1;
    step(); expect_state("r23_acc", 8'h00, 1'b0, 8'h00);
    req_in = 8'h00;
    step();

`ifdef ARB_OVF_CNT_EN
    // Line 5 pulses 300 times while its grant is stalled: 299 hits saturate at 0xFF.
    grant_rdy = 1'b0;
    check("ovf_start", ovf_cnt, 8'h00);
    for (int i = 0; i < 300; i++) begin
      req_in = 8'h20; step();
      req_in = 8'h00; step();
    end
    check("ovf_sat", ovf_cnt, 8'hFF);
    check("ovf_grant", grant, 8'h20);
    #2; rst_n = 1'b0; #1;
    check("ovf_reset", ovf_cnt, 8'h00);
    #1; rst_n = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
